// File: rtl/life_pattern_editor.sv
// Seed editor for the 8x8 Life board. Debounced buttons move a cursor over a shadow board.
// A commit streams every cell, index 0 first, over a valid/ready handshake.
module life_pattern_editor #(
    parameter int BIT_WIDTH       = 3,
    parameter int BIT_HEIGHT      = 3,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   btn_up,
    input  logic                                   btn_down,
    input  logic                                   btn_left,
    input  logic                                   btn_right,
    input  logic                                   btn_toggle,
    input  logic                                   btn_clear,
    input  logic                                   btn_commit,
    output logic [2**(BIT_WIDTH+BIT_HEIGHT)-1:0]   edit_board,
    output logic [BIT_WIDTH-1:0]                   cursor_x,
    output logic [BIT_HEIGHT-1:0]                  cursor_y,
    output logic                                   load_valid,
    output logic [BIT_WIDTH+BIT_HEIGHT-1:0]        load_addr,
    output logic                                   load_data,
    input  logic                                   load_ready,
    output logic                                   load_done,
    output logic                                   busy
);

    localparam int ADDR_W = BIT_WIDTH + BIT_HEIGHT;
    localparam int SIZE   = 2**ADDR_W;
    localparam int NBTN   = 7;
    localparam int CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam int B_UP     = 0;
    localparam int B_DOWN   = 1;
    localparam int B_LEFT   = 2;
    localparam int B_RIGHT  = 3;
    localparam int B_TOGGLE = 4;
    localparam int B_CLEAR  = 5;
    localparam int B_COMMIT = 6;

    typedef enum logic [1:0] {
        EDIT,
        STREAM,
        DONE
    } state_t;

    logic [NBTN-1:0]       w_raw;
    logic [NBTN-1:0]       r_sync1;
    logic [NBTN-1:0]       r_sync2;
    logic [NBTN-1:0]       r_deb;
    logic [NBTN-1:0]       w_flip;
    logic [NBTN-1:0]       w_press;
    logic [CNT_W-1:0]      r_cnt [NBTN];

    state_t                r_state;
    logic [SIZE-1:0]       r_board;
    logic [BIT_WIDTH-1:0]  r_cursorX;
    logic [BIT_HEIGHT-1:0] r_cursorY;
    logic [BIT_WIDTH-1:0]  w_nextX;
    logic [BIT_HEIGHT-1:0] w_nextY;
    logic [ADDR_W-1:0]     w_idx;
    logic                  r_loadValid;
    logic [ADDR_W-1:0]     r_loadAddr;
    logic                  r_loadDone;
    logic                  r_busy;

    assign w_raw = {btn_commit, btn_clear, btn_toggle, btn_right, btn_left, btn_down, btn_up};

    // The press pulse coincides with the edge on which the debounced level rises.
    always_comb begin
        w_flip  = '0;
        w_press = '0;
        for (int i = 0; i < NBTN; i++) begin
            w_flip[i]  = (r_sync2[i] != r_deb[i]) && (r_cnt[i] == CNT_LAST);
            w_press[i] = w_flip[i] && r_sync2[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            for (int i = 0; i < NBTN; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < NBTN; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_flip[i]) begin
                    r_cnt[i] <= '0;
                    r_deb[i] <= ~r_deb[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Opposing moves cancel; the board width is a power of two, so wrap is free.
    always_comb begin
        w_nextX = r_cursorX;
        w_nextY = r_cursorY;
        if (w_press[B_LEFT] && !w_press[B_RIGHT]) begin
            w_nextX = r_cursorX - BIT_WIDTH'(1);
        end else if (w_press[B_RIGHT] && !w_press[B_LEFT]) begin
            w_nextX = r_cursorX + BIT_WIDTH'(1);
        end
        if (w_press[B_UP] && !w_press[B_DOWN]) begin
            w_nextY = r_cursorY - BIT_HEIGHT'(1);
        end else if (w_press[B_DOWN] && !w_press[B_UP]) begin
            w_nextY = r_cursorY + BIT_HEIGHT'(1);
        end
    end

    assign w_idx = {r_cursorY, r_cursorX};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= EDIT;
            r_board     <= '0;
            r_cursorX   <= '0;
            r_cursorY   <= '0;
            r_loadValid <= 1'b0;
            r_loadAddr  <= '0;
            r_loadDone  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                EDIT: begin
                    if (w_press[B_CLEAR]) begin
                        r_board <= '0;
                    end else begin
                        if (w_press[B_TOGGLE]) begin
                            r_board <= r_board ^ (SIZE'(1) << w_idx);
                        end
                        r_cursorX <= w_nextX;
                        r_cursorY <= w_nextY;
                    end
                    if (w_press[B_COMMIT]) begin
                        r_state     <= STREAM;
                        r_loadValid <= 1'b1;
                        r_loadAddr  <= '0;
                        r_busy      <= 1'b1;
                    end
                end
                STREAM: begin
                    if (r_loadValid && load_ready) begin
                        if (r_loadAddr == ADDR_W'(SIZE - 1)) begin
                            r_state     <= DONE;
                            r_loadValid <= 1'b0;
                            r_loadDone  <= 1'b1;
                        end else begin
                            r_loadAddr <= r_loadAddr + ADDR_W'(1);
                        end
                    end
                end
                DONE: begin
                    r_state    <= EDIT;
                    r_loadDone <= 1'b0;
                    r_busy     <= 1'b0;
                    r_loadAddr <= '0;
                end
                default: begin
                    r_state <= EDIT;
                end
            endcase
        end
    end

    assign edit_board = r_board;
    assign cursor_x   = r_cursorX;
    assign cursor_y   = r_cursorY;
    assign load_valid = r_loadValid;
    assign load_addr  = r_loadAddr;
    assign load_data  = r_board[r_loadAddr];
    assign load_done  = r_loadDone;
    assign busy       = r_busy;

endmodule

// File: tb/tb_life_pattern_editor.sv
// Directed bench for life_pattern_editor with a 4-cycle debounce.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_life_pattern_editor;

    localparam logic [6:0] UP     = 7'b000_0001;
    localparam logic [6:0] DOWN   = 7'b000_0010;
    localparam logic [6:0] LEFT   = 7'b000_0100;
    localparam logic [6:0] RIGHT  = 7'b000_1000;
    localparam logic [6:0] TOGGLE = 7'b001_0000;
    localparam logic [6:0] CLEAR  = 7'b010_0000;
    localparam logic [6:0] COMMIT = 7'b100_0000;

    logic        clk;
    logic        reset;
    logic [6:0]  btnVec;
    logic        btn_up, btn_down, btn_left, btn_right;
    logic        btn_toggle, btn_clear, btn_commit;
    logic [63:0] edit_board;
    logic [2:0]  cursor_x;
    logic [2:0]  cursor_y;
    logic        load_valid;
    logic [5:0]  load_addr;
    logic        load_data;
    logic        load_ready;
    logic        load_done;
    logic        busy;

    int          total;
    int          bad;
    logic [63:0] expBoard;

    assign {btn_commit, btn_clear, btn_toggle, btn_right, btn_left, btn_down, btn_up} = btnVec;

    life_pattern_editor #(
        .BIT_WIDTH      (3),
        .BIT_HEIGHT     (3),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_toggle (btn_toggle),
        .btn_clear  (btn_clear),
        .btn_commit (btn_commit),
        .edit_board (edit_board),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y),
        .load_valid (load_valid),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .load_ready (load_ready),
        .load_done  (load_done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Hold the buttons long enough to register, then let the release settle.
    task automatic applyStimulus(input logic [6:0] mask);
        btnVec = mask;
        repeat (8) @(negedge clk);
        btnVec = '0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        int  expAddr;
        logic rdy;

        total      = 0;
        bad        = 0;
        reset      = 1'b0;
        btnVec     = '0;
        load_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        checkOutput("rst_board",  edit_board, 64'd0);
        checkOutput("rst_cursor", 64'({cursor_y, cursor_x}), 64'd0);
        checkOutput("rst_stream", 64'({load_valid, load_addr, load_done, busy}), 64'd0);

        btnVec = TOGGLE;
        repeat (3) @(negedge clk);
        btnVec = '0;
        repeat (12) @(negedge clk);
        checkOutput("glitch_board", edit_board, 64'd0);

        btnVec = TOGGLE;
        repeat (5) @(negedge clk);
        checkOutput("tgl_edge5", edit_board, 64'd0);
        @(negedge clk);
        checkOutput("tgl_edge6", edit_board, 64'd1);
        repeat (14) @(negedge clk);
        btnVec = '0;
        checkOutput("tgl_held", edit_board, 64'd1);
        repeat (10) @(negedge clk);
        checkOutput("tgl_release", edit_board, 64'd1);

        applyStimulus(LEFT);
        applyStimulus(UP);
        checkOutput("wrap_77", 64'({cursor_y, cursor_x}), 64'({3'd7, 3'd7}));
        applyStimulus(RIGHT | DOWN);
        checkOutput("diag_00", 64'({cursor_y, cursor_x}), 64'd0);
        applyStimulus(UP | DOWN);
        checkOutput("updown_cancel", 64'({cursor_y, cursor_x}), 64'd0);

        applyStimulus(RIGHT);
        applyStimulus(RIGHT);
        applyStimulus(RIGHT);
        applyStimulus(DOWN);
        applyStimulus(DOWN);
        checkOutput("cursor_32", 64'({cursor_y, cursor_x}), 64'({3'd2, 3'd3}));
        applyStimulus(TOGGLE);
        checkOutput("tgl_19", edit_board, 64'h0000_0000_0008_0001);
        applyStimulus(CLEAR | TOGGLE);
        checkOutput("clear_prio", edit_board, 64'd0);
        checkOutput("clear_cursor", 64'({cursor_y, cursor_x}), 64'({3'd2, 3'd3}));

        applyStimulus(LEFT);
        applyStimulus(LEFT);
        applyStimulus(LEFT);
        applyStimulus(UP);
        applyStimulus(UP);
        applyStimulus(TOGGLE);
        applyStimulus(RIGHT);
        applyStimulus(RIGHT);
        applyStimulus(RIGHT);
        applyStimulus(TOGGLE | RIGHT);
        applyStimulus(UP);
        applyStimulus(TOGGLE);
        expBoard = 64'h1000_0000_0000_0009;
        checkOutput("pattern_board", edit_board, expBoard);
        checkOutput("pattern_cursor", 64'({cursor_y, cursor_x}), 64'({3'd7, 3'd4}));

        load_ready = 1'b1;
        btnVec = COMMIT;
        repeat (6) @(negedge clk);
        btnVec = '0;
        for (int i = 0; i < 64; i++) begin
            checkOutput($sformatf("beat%0d", i),
                        64'({load_valid, load_addr, load_data, busy, load_done}),
                        64'({1'b1, 6'(i), expBoard[i], 1'b1, 1'b0}));
            @(negedge clk);
        end
        checkOutput("done_pulse", 64'({load_valid, load_done, busy}), 64'(3'b011));
        @(negedge clk);
        checkOutput("after_done", 64'({load_valid, load_done, busy, load_addr}), 64'd0);

        load_ready = 1'b0;
        repeat (10) @(negedge clk);
        btnVec = COMMIT;
        repeat (6) @(negedge clk);
        btnVec  = '0;
        expAddr = 0;
        for (int cyc = 0; cyc < 400 && expAddr < 64; cyc++) begin
            checkOutput($sformatf("bp_beat%0d", expAddr),
                        64'({load_valid, load_addr, load_data}),
                        64'({1'b1, 6'(expAddr), expBoard[expAddr]}));
            if (cyc == 20) btnVec = TOGGLE;
            if (cyc == 40) btnVec = '0;
            rdy        = (cyc % 3 == 2);
            load_ready = rdy;
            @(negedge clk);
            if (rdy) expAddr++;
        end
        checkOutput("bp_complete", 64'(expAddr), 64'd64);
        checkOutput("bp_done", 64'({load_valid, load_done, busy}), 64'(3'b011));
        load_ready = 1'b0;
        @(negedge clk);
        checkOutput("bp_idle", 64'({load_valid, load_done, busy}), 64'd0);
        checkOutput("bp_board_frozen", edit_board, expBoard);
        checkOutput("bp_cursor_frozen", 64'({cursor_y, cursor_x}), 64'({3'd7, 3'd4}));

        repeat (10) @(negedge clk);
        load_ready = 1'b1;
        btnVec = COMMIT;
        repeat (6) @(negedge clk);
        btnVec = '0;
        repeat (20) @(negedge clk);
        checkOutput("mid_addr20", 64'({load_valid, load_addr}), 64'({1'b1, 6'd20}));
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checkOutput("mid_rst_stream", 64'({load_valid, load_addr, load_done, busy}), 64'd0);
        checkOutput("mid_rst_board", edit_board, 64'd0);
        checkOutput("mid_rst_cursor", 64'({cursor_y, cursor_x}), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput($sformatf("mid_no_done%0d", i), 64'({load_valid, load_done}), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/life_pattern_editor.md
Name: life_pattern_editor

Overview:
- Upstream seed source for the 8x8 Life board.
- Debounces front-panel buttons and moves an edit cursor over a shadow copy of the board. Cells under the cursor can be toggled, or the whole board cleared.
- On commit, streams all 64 cells, index 0 first, to the board-update stage over a valid/ready handshake.
- Exposes the shadow board and cursor to the pixel stage for an overlay.

Parameters:
BIT_WIDTH, 3, log2 of board width; BOARD_WIDTH = 2**BIT_WIDTH
BIT_HEIGHT, 3, log2 of board height; SIZE = 2**(BIT_WIDTH+BIT_HEIGHT)
DEBOUNCE_CYCLES, 250000, consecutive stable clk cycles before a debounced level changes (bench uses 4)

Ports:
clk  input  1  pixel clock
reset  input  1  synchronous, active-low
btn_up, btn_down, btn_left, btn_right  input  1 each  raw, asynchronous, active-high
btn_toggle, btn_clear, btn_commit  input  1 each  raw, asynchronous, active-high
edit_board  output  SIZE  shadow board; bit k = cell at row k/BOARD_WIDTH, column k%BOARD_WIDTH
cursor_x  output  BIT_WIDTH  cursor column
cursor_y  output  BIT_HEIGHT  cursor row
load_valid  output  1  stream beat valid
load_addr  output  BIT_WIDTH+BIT_HEIGHT  cell index of current beat
load_data  output  1  cell value of current beat
load_ready  input  1  consumer accepts the beat
load_done  output  1  one-cycle pulse after the last beat is accepted
busy  output  1  high while not in EDIT

Behaviour:
- Reset values (reset==0 at a clk edge):
  - edit_board=0, cursor=(0,0), load_valid=0, load_addr=0, load_done=0, busy=0, state=EDIT.
  - Synchronizers and debounced levels = 0; debounce counters = 0.
- Input conditioning, per button:
  - 2-flop synchronizer.
  - Counter increments while the synced level != debounced level; it clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the mismatch persists, the debounced level flips and the counter clears.
  - A press pulse (1 cycle) is generated on the debounced rising edge.
  - Raw edge to pulse latency = 2 + DEBOUNCE_CYCLES cycles.
  - A button held through reset produces a press once the debounce completes after reset release.
- FSM states: EDIT, STREAM, DONE.
- EDIT, press pulses evaluated in the same cycle, in priority order:
  - clear: edit_board <= 0; toggle and moves are ignored that cycle; cursor is unchanged.
  - toggle: flips edit_board[cursor_y*BOARD_WIDTH+cursor_x] at the pre-move cursor position. Moves in the same cycle still apply.
  - Moves: up decrements cursor_y, down increments it; left decrements cursor_x, right increments it. All modulo board size (wrap: 0-1 = 7, 7+1 = 0).
  - up+down together cancel; left+right together cancel; a vertical and a horizontal move together give a diagonal step.
  - commit: transition to STREAM; load_addr <= 0. Commit has the lowest priority, but same-cycle clear/toggle/moves still take effect before streaming.
- STREAM:
  - load_valid=1, load_data=edit_board[load_addr] (combinational from the frozen board), busy=1.
  - On load_valid && load_ready: if load_addr==SIZE-1, go to DONE; else load_addr increments.
  - load_valid, load_addr and load_data stay stable until accepted.
  - load_ready while load_valid is low has no effect.
  - edit_board and cursor are frozen; all press pulses in STREAM and DONE are dropped, not queued.
  - Minimum stream length = SIZE cycles (ready held high).
- DONE: load_valid=0, load_done=1 for exactly one cycle, busy=1; next state EDIT with load_addr=0.
- Reset asserted mid-stream: all outputs return to reset values on that edge. The consumer observes load_valid fall with no load_done.
- Sequential logic is on posedge clk only; there is no other clock domain inside the block.

Test Plan:
- Debounce (DEBOUNCE_CYCLES=4): a 3-cycle btn_toggle glitch -> edit_board unchanged. A clean 20-cycle press -> bit 0 flips, exactly once, 6 cycles after the raw edge.
- Wrap/cursor: from reset, press left then up -> cursor (7,7). Press right+down simultaneously -> (0,0). Press up+down together -> cursor_y unchanged.
- Toggle/clear priority: toggle at (3,2) -> edit_board[19]=1. Press clear+toggle in the same cycle -> edit_board all zero.
- Full stream, ready held high: edit_board with bits 0,3,60 set, then commit -> 64 beats, addr 0..63 in consecutive cycles, data=1 only at addr 0,3,60. load_done pulses once, the cycle after beat 63; busy falls the cycle after that.
- Back-pressure: toggle ready every 3rd cycle -> no beat skipped or repeated, addr/data stable while ready is low. A btn_toggle pressed during the stream -> edit_board unchanged after return to EDIT.
- Reset mid-stream at addr 20 -> next cycle load_valid=0, load_addr=0, edit_board=0, cursor=(0,0), no load_done pulse.
